// File: rtl/mdio_responder.sv
// Clause 22 MDIO PHY-side responder: oversamples mdc/mdio on clk, decodes frames for PHY_ADDR.
// Optional build macro MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN: accept ST after a single preamble 1.
module mdio_responder #(
    parameter logic [4:0] PHY_ADDR     = 5'd1,
    parameter int         PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    inout  wire         mdio,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rdata,
    output logic        frame_error
);
    localparam logic [2:0] ST_PREAMBLE = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_HEADER   = 3'd2;
    localparam logic [2:0] ST_TA       = 3'd3;
    localparam logic [2:0] ST_DATA     = 3'd4;
    localparam logic [2:0] ST_SKIP     = 3'd5;

    localparam int CNT_W = $clog2(PREAMBLE_LEN + 1);
    localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(PREAMBLE_LEN);
`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN
    localparam logic [CNT_W-1:0] PRE_NEED = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] PRE_NEED = CNT_W'(PREAMBLE_LEN);
`endif

    // Pure synchronizer pipeline; left out of reset so a reset never fabricates an mdc edge.
    logic mdc_s1_q, mdc_s2_q, mdc_prev_q, mdio_s1_q, mdio_s2_q;
    always_ff @(posedge clk) begin
        mdc_s1_q   <= mdc;
        mdc_s2_q   <= mdc_s1_q;
        mdc_prev_q <= mdc_s2_q;
        mdio_s1_q  <= mdio;
        mdio_s2_q  <= mdio_s1_q;
    end

    logic mdc_rise, bit_in;
    assign mdc_rise = mdc_s2_q & ~mdc_prev_q;
    assign bit_in   = mdio_s2_q;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [15:0]      shift_q, shift_d;
    logic             is_read_q, is_read_d;
    logic             rd_cap_q, rd_cap_d;
    logic             oe_q, oe_d, out_q, out_d;
    logic [4:0]       reg_addr_q, reg_addr_d;
    logic [15:0]      reg_wdata_q, reg_wdata_d;
    logic             wr_en_q, wr_en_d, rd_en_q, rd_en_d, err_q, err_d;

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        is_read_d   = is_read_q;
        oe_d        = oe_q;
        out_d       = out_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        err_d       = 1'b0;
        rd_cap_d    = rd_en_q;
        // Register port has one cycle of read latency; the next mdc edge is at least 6 clk away.
        if (rd_cap_q) shift_d = reg_rdata;
        if (mdc_rise) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            case (state_q)
                ST_PREAMBLE: begin
                    if (bit_in) begin
                        pre_cnt_d = (pre_cnt_q == PRE_MAX) ? pre_cnt_q : pre_cnt_q + CNT_W'(1);
                    end else if (pre_cnt_q >= PRE_NEED) begin
                        state_d   = ST_START;
                        bit_cnt_d = 6'd1;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                ST_START: begin
                    if (bit_in) begin
                        state_d = ST_HEADER;
                    end else begin
                        err_d     = 1'b1;
                        state_d   = ST_PREAMBLE;
                        pre_cnt_d = '0;
                    end
                end
                ST_HEADER: begin
                    shift_d = {shift_q[14:0], bit_in};
                    if (bit_cnt_q == 6'd3) begin
                        is_read_d = shift_q[0] & ~bit_in;
                        if (shift_q[0] == bit_in) begin
                            err_d     = 1'b1;
                            state_d   = ST_PREAMBLE;
                            pre_cnt_d = '0;
                        end
                    end else if (bit_cnt_q == 6'd13) begin
                        // shift_q[8:4] holds PHYAD, shift_q[3:0] the upper REGAD bits.
                        reg_addr_d = {shift_q[3:0], bit_in};
                        if (shift_q[8:4] != PHY_ADDR) begin
                            state_d = ST_SKIP;
                        end else begin
                            state_d = ST_TA;
                            rd_en_d = is_read_q;
                        end
                    end
                end
                ST_TA: begin
                    if (bit_cnt_q == 6'd14) begin
                        if (is_read_q) begin
                            oe_d  = 1'b1;
                            out_d = 1'b0;
                        end
                    end else begin
                        if (is_read_q) begin
                            out_d   = shift_q[15];
                            shift_d = {shift_q[14:0], 1'b0};
                        end
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_q == 6'd31) begin
                        state_d   = ST_PREAMBLE;
                        pre_cnt_d = '0;
                        oe_d      = 1'b0;
                        if (!is_read_q) begin
                            reg_wdata_d = {shift_q[14:0], bit_in};
                            wr_en_d     = 1'b1;
                        end
                    end else if (is_read_q) begin
                        out_d   = shift_q[15];
                        shift_d = {shift_q[14:0], 1'b0};
                    end else begin
                        shift_d = {shift_q[14:0], bit_in};
                    end
                end
                ST_SKIP: begin
                    if (bit_cnt_q == 6'd31) begin
                        state_d   = ST_PREAMBLE;
                        pre_cnt_d = '0;
                    end
                end
                default: begin
                    state_d   = ST_PREAMBLE;
                    pre_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_PREAMBLE;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            is_read_q   <= 1'b0;
            rd_cap_q    <= 1'b0;
            oe_q        <= 1'b0;
            out_q       <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            is_read_q   <= is_read_d;
            rd_cap_q    <= rd_cap_d;
            oe_q        <= oe_d;
            out_q       <= out_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            err_q       <= err_d;
        end
    end

    assign mdio        = oe_q ? out_q : 1'bz;
    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_rd_en   = rd_en_q;
    assign frame_error = err_q;
endmodule

// File: doc/mdio_responder.md
# mdio_responder

PHY-side (slave) end of the Clause 22 MDIO management interface. Oversamples an externally driven `mdc`/`mdio` pair on the local clock and decodes 32-bit management frames addressed to its own PHY address. Write frames go to a simple register port; read frames fetch register data and shift it back onto `mdio`. Used as the PHY model in MAC-level benches and as the management front end of on-chip PHY/PCS blocks.

## Interface
- `PHY_ADDR`, default 5'd1: address this responder answers to.
- `PREAMBLE_LEN`, default 32: number of consecutive sampled 1s required before a start pattern is accepted.
- `clk  input  1`: system clock; every register is on its rising edge.
- `reset  input  1`: synchronous, active-high reset.
- `mdc  input  1`: management clock from the station; asynchronous to `clk`.
- `mdio  inout  1`: management data; driven only when the output enable is set, otherwise `1'bz`.
- `reg_addr  output  5`: REGAD of the current frame.
- `reg_wdata  output  16`: write data; valid while `reg_wr_en`=1.
- `reg_wr_en  output  1`: one-cycle write strobe.
- `reg_rd_en  output  1`: one-cycle read request.
- `reg_rdata  input  16`: read data, sampled exactly 1 clk after `reg_rd_en`.
- `frame_error  output  1`: one-cycle pulse on a bad ST or OP.

## Operation
- Input sync: `mdc` and `mdio` each pass through 2 flops. A rising edge is sync'd `mdc` 0 in the previous cycle and 1 in the current cycle. `mdio` is sampled only on a detected rising edge.
- Frame bit numbering, counting sampled edges after the preamble:
  - 1–2: ST, must be 01.
  - 3–4: OP, 01 = write, 10 = read.
  - 5–9: PHYAD, MSB first.
  - 10–14: REGAD, MSB first.
  - 15–16: TA.
  - 17–32: DATA, MSB first.
- FSM states:
  - PREAMBLE: count consecutive 1s, saturating at `PREAMBLE_LEN`. A 0 before the count is reached clears the count. A 0 once the count is reached means ST bit 1; go to START.
  - START: a sampled 1 goes to HEADER. A sampled 0 pulses `frame_error` and returns to PREAMBLE with the count cleared.
  - HEADER: shift in bits 3–14. After bit 4, OP 00 or 11 pulses `frame_error` and returns to PREAMBLE. After bit 14, set `reg_addr`.
    - PHYAD != `PHY_ADDR`: go to SKIP.
    - Read: pulse `reg_rd_en` in the cycle after the bit-14 edge, load `reg_rdata` into the shift register 1 clk later, then go to TA.
    - Write: go to TA.
  - TA:
    - Read: after the bit-15 edge, assert the output enable and drive 0. After the bit-16 edge, drive D15. Go to DATA.
    - Write: TA bits are ignored. Go to DATA.
  - DATA:
    - Read: after each of edges 17–31, drive the next bit (D14..D0). After edge 32, release `mdio` (OE=0).
    - Write: shift in 16 bits. On the cycle after edge 32, pulse `reg_wr_en` with `reg_wdata`.
    - Both: return to PREAMBLE with the count cleared.
  - SKIP: count to edge 32 without driving or strobing, then go to PREAMBLE.
- Output updates happen only in the cycle after a detected rising edge. The station then sees stable data across the low phase of `mdc`.
- Reset values:
  - State PREAMBLE, count 0.
  - OE=0, so `mdio` is Z.
  - `reg_addr`=0, `reg_wdata`=0.
  - `reg_wr_en`, `reg_rd_en`, `frame_error` all 0.
- Reset mid-frame: on the next clk, `mdio` is released and the FSM is in PREAMBLE. No strobe is issued for the aborted frame.

## Timing
- `mdc` high and low phases must each be ≥3 clk.
- Pin-to-edge-detect latency: 2–3 clk.
- Edge-to-pin latency for driven bits: 1 clk.
- Read data: `reg_rd_en` at E14+1, `reg_rdata` captured at E14+2. The bit-15 edge cannot arrive sooner (≥6 clk later).
- `reg_wr_en` is high for exactly 1 clk per accepted write. At most one strobe per frame.
- `frame_error` and the strobes are never asserted in the same cycle.

## Configuration
- `MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN`
  - Defined: the PREAMBLE state needs only 1 sampled 1 before ST bit 1 is accepted, regardless of `PREAMBLE_LEN`. This supports stations that omit the preamble.
  - Undefined: `PREAMBLE_LEN` consecutive 1s are mandatory. A frame sent without a full preamble is ignored entirely, with no strobes and no `frame_error`.

## Test plan
- **Write:** 32×1 preamble, then frame 01_01_00001_00100_10_0xBEEF.
  - `reg_wr_en` pulses once with `reg_addr`=4, `reg_wdata`=16'hBEEF.
  - `mdio` stays Z throughout.
- **Read:** preamble, then 01_10_00001_00010, station releases for TA/DATA, `reg_rdata`=16'h1234.
  - `reg_rd_en` pulses once.
  - Responder drives TA bit 2 = 0, then 0001_0010_0011_0100 on bits 17–32.
  - `mdio` returns to Z after edge 32.
- **Address mismatch:** read frame with PHYAD 5'd7 while `PHY_ADDR`=1.
  - No strobes; `mdio` Z for all 32 bits.
  - A following valid write is accepted.
- **Bad frame:**
  - ST 00 → `frame_error` pulses once after bit 2.
  - OP 11 → `frame_error` pulses once after bit 4.
  - Neither produces a strobe.
- **Short preamble:** 10×1 preamble, then a write frame.
  - Macro undefined: nothing happens.
  - Macro defined: `reg_wr_en` pulses with the frame's data.
- **Reset mid-read:** `reset` high for 1 clk during DATA bit 24.
  - `mdio` is Z the next clk and stays Z for the remainder of the frame.
  - The next full frame decodes correctly.
